// File: rtl/i2c_cmd_queue.sv
// Command queue and RX byte buffer sitting between the TinyQV I2C_DATA MMIO slot and the I2C bridge.
// Commands are issued one at a time and paced by bridge status; received bytes are drained automatically.
module i2c_cmd_queue #(
  parameter int DEPTH    = 4,
  parameter int RX_DEPTH = 4,
  parameter int TIMEOUT  = 200000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] cpu_data_in,
  input  logic        cpu_wr,
  input  logic        cpu_rd,
  output logic [31:0] cpu_data_out,
  output logic [12:0] br_data_in,
  output logic        br_data_wr,
  output logic        br_data_rd,
  input  logic [11:0] br_status
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = $clog2(RX_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0] CMD_MAX = 4'(DEPTH);
  localparam logic [3:0] RX_MAX  = 4'(RX_DEPTH);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ISSUE  = 2'd1;
  localparam logic [1:0] S_SETTLE = 2'd2;
  localparam logic [1:0] S_WAIT   = 2'd3;

  localparam logic [1:0] C_IMM  = 2'd0;
  localparam logic [1:0] C_DATA = 2'd1;
  localparam logic [1:0] C_READ = 2'd2;
  localparam logic [1:0] C_STOP = 2'd3;

  // WAIT exit class; read takes precedence, then plain data writes, then a bare stop
  function automatic logic [1:0] classify(input logic [12:0] w);
    logic [1:0] c;
    if (w[9]) begin
      c = C_READ;
    end else if ((w[10] | w[11]) & ~w[8]) begin
      c = C_DATA;
    end else if (w[12] & ~w[8]) begin
      c = C_STOP;
    end else begin
      c = C_IMM;
    end
    return c;
  endfunction

  logic [12:0]   cmd_mem_q [DEPTH];
  logic [12:0]   cmd_mem_d [DEPTH];
  logic [AW-1:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d;
  logic [3:0]    cmd_cnt_q, cmd_cnt_d;
  logic [7:0]    rx_mem_q [RX_DEPTH];
  logic [7:0]    rx_mem_d [RX_DEPTH];
  logic [RW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [3:0]    rx_cnt_q, rx_cnt_d;
  logic [1:0]    state_q, state_d, cls_q, cls_d;
  logic          settle_q, settle_d;
  logic [TW-1:0] wait_cnt_q, wait_cnt_d;
  logic          nack_q, nack_d, ovf_q, ovf_d, tmo_q, tmo_d;
  logic          rd_prev_q, rd_prev_d;

  logic        flush_s, push_req_s, push_s, pop_s, cmd_empty_s, cmd_full_s;
  logic        rx_full_s, rx_empty_s, rx_cap_s, rx_pop_s, wait_exit_s, tmo_set_s, busy_s;
  logic [12:0] head_s;
  logic        unused_s;

  assign unused_s    = ^cpu_data_in[30:13];
  assign flush_s     = cpu_wr & cpu_data_in[31];
  assign push_req_s  = cpu_wr & ~cpu_data_in[31];
  assign cmd_empty_s = (cmd_cnt_q == 4'd0);
  assign cmd_full_s  = (cmd_cnt_q == CMD_MAX);
  assign pop_s       = (state_q == S_ISSUE) & ~cmd_empty_s;
  assign push_s      = push_req_s & (~cmd_full_s | pop_s);
  assign head_s      = cmd_mem_q[cmd_rp_q];
  assign rx_empty_s  = (rx_cnt_q == 4'd0);
  assign rx_full_s   = (rx_cnt_q == RX_MAX);
  // The one-cycle gap after each read strobe gives the bridge time to drop rx_valid
  assign rx_cap_s    = br_status[10] & ~rx_full_s & ~rd_prev_q;
  assign rx_pop_s    = cpu_rd & ~rx_empty_s;
  assign busy_s      = (state_q != S_IDLE) | ~cmd_empty_s | br_status[9];

  // Command FIFO next-state
  always_comb begin
    cmd_mem_d = cmd_mem_q;
    cmd_wp_d  = cmd_wp_q;
    cmd_rp_d  = cmd_rp_q;
    cmd_cnt_d = cmd_cnt_q;
    if (flush_s) begin
      cmd_wp_d  = '0;
      cmd_rp_d  = '0;
      cmd_cnt_d = 4'd0;
    end else begin
      if (push_s) begin
        cmd_mem_d[cmd_wp_q] = cpu_data_in[12:0];
        cmd_wp_d = cmd_wp_q + AW'(1);
      end else begin
        cmd_wp_d = cmd_wp_q;
      end
      cmd_rp_d  = pop_s ? cmd_rp_q + AW'(1) : cmd_rp_q;
      cmd_cnt_d = cmd_cnt_q + {3'd0, push_s} - {3'd0, pop_s};
    end
  end

  // RX FIFO next-state
  always_comb begin
    rx_mem_d  = rx_mem_q;
    rx_wp_d   = rx_wp_q;
    rx_rp_d   = rx_rp_q;
    rx_cnt_d  = rx_cnt_q;
    rd_prev_d = rx_cap_s;
    if (flush_s) begin
      rx_wp_d  = '0;
      rx_rp_d  = '0;
      rx_cnt_d = 4'd0;
    end else begin
      if (rx_cap_s) begin
        rx_mem_d[rx_wp_q] = br_status[7:0];
        rx_wp_d = rx_wp_q + RW'(1);
      end else begin
        rx_wp_d = rx_wp_q;
      end
      rx_rp_d  = rx_pop_s ? rx_rp_q + RW'(1) : rx_rp_q;
      rx_cnt_d = rx_cnt_q + {3'd0, rx_cap_s} - {3'd0, rx_pop_s};
    end
  end

  // WAIT exit condition for the class latched at issue
  always_comb begin
    case (cls_q)
      C_DATA:  wait_exit_s = ~br_status[11];
      C_READ:  wait_exit_s = rx_cap_s;
      C_STOP:  wait_exit_s = ~br_status[9];
      default: wait_exit_s = 1'b1;
    endcase
  end

  // Issue FSM; a satisfied WAIT chains straight into ISSUE to keep the 4-cycle cadence
  always_comb begin
    state_d    = state_q;
    cls_d      = cls_q;
    settle_d   = settle_q;
    wait_cnt_d = wait_cnt_q;
    tmo_set_s  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!cmd_empty_s) begin
          state_d = S_ISSUE;
          cls_d   = classify(head_s);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        state_d  = S_SETTLE;
        settle_d = 1'b0;
      end
      S_SETTLE: begin
        if (settle_q) begin
          state_d    = S_WAIT;
          wait_cnt_d = '0;
        end else begin
          settle_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (wait_exit_s) begin
          if (!cmd_empty_s) begin
            state_d = S_ISSUE;
            cls_d   = classify(head_s);
          end else begin
            state_d = S_IDLE;
          end
        end else if (wait_cnt_q == TMO_LAST) begin
          tmo_set_s = 1'b1;
          state_d   = S_IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_s) begin
      state_d = S_IDLE;
    end else begin
      state_d = state_d;
    end
  end

  // Sticky error flags, cleared only by flush
  always_comb begin
    if (flush_s) begin
      nack_d = 1'b0;
      ovf_d  = 1'b0;
      tmo_d  = 1'b0;
    end else begin
      nack_d = nack_q | br_status[8];
      ovf_d  = ovf_q | (push_req_s & ~push_s);
      tmo_d  = tmo_q | tmo_set_s;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) cmd_mem_q[i] <= 13'd0;
      for (int i = 0; i < RX_DEPTH; i++) rx_mem_q[i] <= 8'd0;
      cmd_wp_q   <= '0;
      cmd_rp_q   <= '0;
      cmd_cnt_q  <= 4'd0;
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      rx_cnt_q   <= 4'd0;
      state_q    <= S_IDLE;
      cls_q      <= C_IMM;
      settle_q   <= 1'b0;
      wait_cnt_q <= '0;
      nack_q     <= 1'b0;
      ovf_q      <= 1'b0;
      tmo_q      <= 1'b0;
      rd_prev_q  <= 1'b0;
    end else begin
      cmd_mem_q  <= cmd_mem_d;
      rx_mem_q   <= rx_mem_d;
      cmd_wp_q   <= cmd_wp_d;
      cmd_rp_q   <= cmd_rp_d;
      cmd_cnt_q  <= cmd_cnt_d;
      rx_wp_q    <= rx_wp_d;
      rx_rp_q    <= rx_rp_d;
      rx_cnt_q   <= rx_cnt_d;
      state_q    <= state_d;
      cls_q      <= cls_d;
      settle_q   <= settle_d;
      wait_cnt_q <= wait_cnt_d;
      nack_q     <= nack_d;
      ovf_q      <= ovf_d;
      tmo_q      <= tmo_d;
      rd_prev_q  <= rd_prev_d;
    end
  end

  assign br_data_wr   = (state_q == S_ISSUE);
  assign br_data_in   = br_data_wr ? head_s : 13'd0;
  assign br_data_rd   = rx_cap_s;
  assign cpu_data_out = {8'd0, rx_cnt_q, cmd_cnt_q, 2'b00, tmo_q, ovf_q, cmd_full_s, busy_s,
                         nack_q, ~rx_empty_s, rx_empty_s ? 8'd0 : rx_mem_q[rx_rp_q]};

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Bench for i2c_cmd_queue: queue-level scoreboard checked every cycle, a small bridge model,
// and directed scenarios with literal expectations.
module tb_i2c_cmd_queue;
  localparam int DEPTH = 4;
  localparam int RX_DEPTH = 4;
  localparam int TMO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [31:0] cpu_data_in = 32'd0;
  logic cpu_wr = 1'b0, cpu_rd = 1'b0;
  logic [31:0] cpu_data_out;
  logic [12:0] br_data_in;
  logic br_data_wr, br_data_rd;
  logic [11:0] br_status;

  i2c_cmd_queue #(.DEPTH(DEPTH), .RX_DEPTH(RX_DEPTH), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_data_in(cpu_data_in), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
    .cpu_data_out(cpu_data_out), .br_data_in(br_data_in), .br_data_wr(br_data_wr),
    .br_data_rd(br_data_rd), .br_status(br_status));

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- bridge model ----------------
  int tx_pend = 0, rd_delay = 0;
  logic stuck = 1'b0, stuck_act = 1'b0, busy_b = 1'b0, stop_arm = 1'b0, clr_busy = 1'b0;
  logic miss_b = 1'b0, rx_valid_b = 1'b0;
  logic [7:0] rx_byte_b = 8'd0;
  logic [7:0] rx_src[$];
  logic wr_seen_b = 1'b0, rd_seen_b = 1'b0;
  logic [12:0] wword_b = 13'd0;

  assign br_status = {((tx_pend != 0) || stuck_act), rx_valid_b, busy_b, miss_b, rx_byte_b};

  always @(negedge clk) begin
    wr_seen_b = br_data_wr;
    wword_b   = br_data_in;
    rd_seen_b = br_data_rd;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      tx_pend = 0; rd_delay = 0; stuck_act = 1'b0; busy_b = 1'b0; stop_arm = 1'b0;
      rx_valid_b = 1'b0; rx_byte_b = 8'd0; rx_src.delete();
    end else begin
      if (!stuck) stuck_act = 1'b0;
      if (clr_busy) begin busy_b = 1'b0; clr_busy = 1'b0; end
      if (tx_pend > 0) tx_pend--;
      if (wr_seen_b) begin
        if (wword_b[10] | wword_b[11]) begin tx_pend = 10; if (stuck) stuck_act = 1'b1; end
        if (wword_b[8]) busy_b = 1'b1;
        if (wword_b[12]) stop_arm = 1'b1;
        if (wword_b[9]) rd_delay = 5;
      end
      if (stop_arm && tx_pend == 0 && !stuck_act) begin busy_b = 1'b0; stop_arm = 1'b0; end
      if (rd_delay > 0) begin
        rd_delay--;
        if (rd_delay == 0) rx_src.push_back(8'h5A);
      end
      if (rd_seen_b) rx_valid_b = 1'b0;
      else if (!rx_valid_b && rx_src.size() > 0) begin
        rx_valid_b = 1'b1;
        rx_byte_b  = rx_src.pop_front();
      end
    end
  end

  // ---------------- queue-level model and per-cycle compare ----------------
  logic [12:0] mq[$];
  logic [7:0]  mrx[$];
  logic m_ovf = 1'b0, m_nack = 1'b0, m_prev_rd = 1'b0;
  int last_wr = -100, rd_count = 0;
  logic [12:0] wlog[$];
  logic pend_log[$];

  always @(negedge clk) begin
    logic exp_rd, popped;
    if (!rst_n) begin
      mq.delete(); mrx.delete(); m_ovf = 1'b0; m_nack = 1'b0; m_prev_rd = 1'b0; last_wr = -100;
      chk("reset_out", cpu_data_out, 32'd0);
      chk("reset_strobes", {30'd0, br_data_wr, br_data_rd}, 32'd0);
    end else begin
      chk("cmd_count", 32'(cpu_data_out[19:16]), 32'(mq.size()));
      chk("rx_count", 32'(cpu_data_out[23:20]), 32'(mrx.size()));
      chk("rx_head", 32'(cpu_data_out[7:0]), (mrx.size() > 0) ? 32'(mrx[0]) : 32'd0);
      chk("rx_avail", 32'(cpu_data_out[8]), 32'(mrx.size() > 0));
      chk("cmd_full", 32'(cpu_data_out[11]), 32'(mq.size() == DEPTH));
      chk("ovf", 32'(cpu_data_out[12]), 32'(m_ovf));
      chk("nack", 32'(cpu_data_out[9]), 32'(m_nack));
      chk("zero_bits", {cpu_data_out[31:24], 22'd0, cpu_data_out[15:14]}, 32'd0);
      if (mq.size() > 0 || br_status[9]) chk("busy", 32'(cpu_data_out[10]), 32'd1);
      exp_rd = br_status[10] && (mrx.size() < RX_DEPTH) && !m_prev_rd;
      chk("br_data_rd", 32'(br_data_rd), 32'(exp_rd));
      m_prev_rd = exp_rd;
      if (br_data_rd) rd_count++;
      popped = 1'b0;
      if (br_data_wr) begin
        if (mq.size() == 0) chk("issue_from_empty", 32'd1, 32'd0);
        else begin
          chk("issue_word", 32'(br_data_in), 32'(mq[0]));
          void'(mq.pop_front());
        end
        if (last_wr >= 0) chk("issue_gap_ge4", 32'((cyc - last_wr) >= 4), 32'd1);
        last_wr = cyc;
        wlog.push_back(br_data_in);
        pend_log.push_back(br_status[11]);
        popped = 1'b1;
      end
      if (cpu_wr && !cpu_data_in[31]) begin
        if (mq.size() < DEPTH || popped) mq.push_back(cpu_data_in[12:0]);
        else m_ovf = 1'b1;
      end
      if (cpu_rd && mrx.size() > 0) void'(mrx.pop_front());
      if (exp_rd) mrx.push_back(br_status[7:0]);
      if (br_status[8]) m_nack = 1'b1;
      if (cpu_wr && cpu_data_in[31]) begin
        mq.delete(); mrx.delete(); m_ovf = 1'b0; m_nack = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w);
    cpu_data_in = w; cpu_wr = 1'b1;
    tick(1);
    cpu_wr = 1'b0; cpu_data_in = 32'd0;
  endtask

  task automatic flush();
    push(32'h8000_0000);
  endtask

  task automatic pop_rx();
    cpu_rd = 1'b1;
    tick(1);
    cpu_rd = 1'b0;
  endtask

  task automatic wait_wr(input string name, input logic [12:0] w, input int budget);
    logic got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (br_data_wr && br_data_in == w) got = 1'b1;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  initial begin
    int w0;
    logic done;
    tick(3);
    chk("lit_reset_out", cpu_data_out, 32'd0);
    rst_n = 1'b1;
    tick(2);

    // reset asserted while a word is on the bridge
    push(32'h0000_0100);
    wait_wr("rst_wait_issue", 13'h0100, 10);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_wr_drop", 32'(br_data_wr), 32'd0);
    chk("rst_out_zero", cpu_data_out, 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_out", cpu_data_out, 32'd0);

    // three-word write transaction
    wlog.delete(); pend_log.delete();
    push(32'h1150); push(32'h04AB); push(32'h14CD);
    for (int i = 0; i < 100 && wlog.size() < 3; i++) @(negedge clk);
    chk("seq_count", 32'(wlog.size()), 32'd3);
    if (wlog.size() == 3) begin
      chk("seq_w0", 32'(wlog[0]), 32'h1150);
      chk("seq_w1", 32'(wlog[1]), 32'h04AB);
      chk("seq_w2", 32'(wlog[2]), 32'h14CD);
      chk("seq_w2_after_txpend", 32'(pend_log[2]), 32'd0);
    end
    done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!cpu_data_out[10]) done = 1'b1;
    end
    chk("seq_busy_fall", 32'(cpu_data_out[10]), 32'd0);
    chk("seq_bridge_idle", 32'(br_status[9]), 32'd0);
    tick(1);

    // overflow while the bridge stalls, then flush
    stuck = 1'b1;
    push(32'h0411);
    wait_wr("ovf_wait_issue", 13'h0411, 10);
    tick(1);
    for (int i = 1; i <= 5; i++) push(32'h0400 | 32'(i));
    chk("ovf_count", 32'(cpu_data_out[19:16]), 32'd4);
    chk("ovf_flag", 32'(cpu_data_out[12]), 32'd1);
    chk("ovf_full", 32'(cpu_data_out[11]), 32'd1);
    flush();
    chk("flush_count", 32'(cpu_data_out[19:16]), 32'd0);
    chk("flush_ovf", 32'(cpu_data_out[12]), 32'd0);
    stuck = 1'b0;
    tick(3);

    // single-byte read
    rd_count = 0;
    push(32'h0350);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (cpu_data_out[8]) done = 1'b1;
    end
    chk("read_avail", 32'(cpu_data_out[8]), 32'd1);
    chk("read_byte", 32'(cpu_data_out[7:0]), 32'h5A);
    tick(1);
    chk("read_rd_pulses", 32'(rd_count), 32'd1);
    pop_rx();
    chk("read_popped", 32'(cpu_data_out[8]), 32'd0);
    tick(TMO + 10);
    chk("read_no_tmo", 32'(cpu_data_out[13]), 32'd0);
    clr_busy = 1'b1;
    tick(2);

    // RX FIFO full back-pressure
    rd_count = 0;
    rx_src.push_back(8'h11); rx_src.push_back(8'h22); rx_src.push_back(8'h33);
    rx_src.push_back(8'h44); rx_src.push_back(8'h55);
    tick(30);
    chk("rxfull_count", 32'(cpu_data_out[23:20]), 32'd4);
    chk("rxfull_head", 32'(cpu_data_out[7:0]), 32'h11);
    chk("rxfull_rd_pulses", 32'(rd_count), 32'd4);
    pop_rx();
    tick(6);
    chk("rxfull_count_after", 32'(cpu_data_out[23:20]), 32'd4);
    chk("rxfull_head_after", 32'(cpu_data_out[7:0]), 32'h22);
    chk("rxfull_rd_pulses_after", 32'(rd_count), 32'd5);
    for (int i = 0; i < 4; i++) begin pop_rx(); tick(1); end
    chk("rx_drained", 32'(cpu_data_out[23:20]), 32'd0);

    // WAIT timeout keeps the remaining queue
    wlog.delete();
    stuck = 1'b1;
    push(32'h0477); push(32'h0100);
    wait_wr("tmo_wait_issue", 13'h0477, 10);
    w0 = cyc;
    while (cyc < w0 + TMO) @(negedge clk);
    chk("tmo_not_early", 32'(cpu_data_out[13]), 32'd0);
    while (cyc < w0 + TMO + 6) @(negedge clk);
    chk("tmo_set", 32'(cpu_data_out[13]), 32'd1);
    chk("tmo_next_issued", (wlog.size() == 2) ? 32'(wlog[1]) : 32'd0, 32'h0100);
    stuck = 1'b0;
    tick(1);
    flush();
    chk("tmo_flush", 32'(cpu_data_out[13]), 32'd0);
    clr_busy = 1'b1;
    tick(3);

    // missed ACK is sticky until flush
    miss_b = 1'b1;
    tick(1);
    miss_b = 1'b0;
    tick(20);
    chk("nack_sticky", 32'(cpu_data_out[9]), 32'd1);
    flush();
    chk("nack_flush", 32'(cpu_data_out[9]), 32'd0);
    tick(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
